// File: rtl/uart8_jtag_tap_master.sv
// JTAG TAP master: runs one IR/DR scan (or a TAP reset) per command,
// generating TCK/TMS/TDI and capturing TDO. Start and end state of the
// target TAP is always Run-Test/Idle.
module uart8_jtag_tap_master #(
    parameter int CLK_DIV = 2,   // clk cycles per TCK half-period (>= 1)
    parameter int MAX_LEN = 38   // longest scan in bits
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_is_ir,
    input  logic [5:0]         cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    output logic               rsp_valid,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               busy,
    output logic               tck,
    output logic               tms,
    output logic               tdi,
    input  logic               tdo
);

    localparam int LEN_W  = 6;
    localparam int STEP_W = $clog2(MAX_LEN + 7);
    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [2:0] {
        RST_SEQ,
        IDLE,
        HEADER,
        SHIFT,
        TRAILER
    } state_t;

    state_t             state, state_n;
    logic [DIV_W-1:0]   div_cnt, div_cnt_n;
    logic [STEP_W-1:0]  step_cnt, step_cnt_n;
    logic [LEN_W-1:0]   bit_idx, bit_idx_n;
    logic [LEN_W-1:0]   len_q, len_n;
    logic               is_ir_q, is_ir_n;
    logic [MAX_LEN-1:0] data_q, data_n;
    logic [MAX_LEN-1:0] sreg, sreg_n;
    logic [MAX_LEN-1:0] rsp_data_n;
    logic               rsp_pend, rsp_pend_n;
    logic               tck_n, tms_n, tdi_n, rsp_valid_n;
    logic               finish;

    logic [LEN_W-1:0]   len_clamp;
    logic [STEP_W-1:0]  hdr_last;
    logic               half_done;

    // Oversized lengths are silently clamped to the longest supported scan.
    assign len_clamp = (cmd_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cmd_len;
    // Header is 1,0,0 for DR and 1,1,0,0 for IR; index of its last step.
    assign hdr_last  = is_ir_q ? STEP_W'(3) : STEP_W'(2);
    assign half_done = (div_cnt == DIV_W'(CLK_DIV - 1));

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    // Next-state and datapath: each TCK step is a low half then a high half;
    // the step's TMS/TDI are set up when TCK falls at the end of the previous one.
    always_comb begin
        // NOTE: every signal gets its hold value first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_n     = state;
        div_cnt_n   = div_cnt;
        step_cnt_n  = step_cnt;
        bit_idx_n   = bit_idx;
        len_n       = len_q;
        is_ir_n     = is_ir_q;
        data_n      = data_q;
        sreg_n      = sreg;
        rsp_data_n  = rsp_data;
        rsp_pend_n  = rsp_pend;
        tck_n       = tck;
        tms_n       = tms;
        tdi_n       = tdi;
        rsp_valid_n = 1'b0;
        finish      = 1'b0;

        if (state == IDLE) begin
            // Park the TAP in RTI until a command arrives.
            tck_n = 1'b0;
            tms_n = 1'b0;
            tdi_n = 1'b0;
            if (cmd_valid) begin
                is_ir_n    = cmd_is_ir;
                len_n      = len_clamp;
                data_n     = cmd_data;
                sreg_n     = '0;
                rsp_pend_n = 1'b1;
                div_cnt_n  = '0;
                step_cnt_n = '0;
                bit_idx_n  = '0;
                tms_n      = 1'b1;   // first step is TMS=1 for every command type
                state_n    = (len_clamp == '0) ? RST_SEQ : HEADER;
            end
        end else if (!half_done) begin
            div_cnt_n = div_cnt + DIV_W'(1);
        end else begin
            div_cnt_n = '0;
            if (!tck) begin
                // Rising TCK: the target has held TDO stable since the last fall.
                tck_n = 1'b1;
                if (state == SHIFT) sreg_n[bit_idx] = tdo;
            end else begin
                // Falling TCK ends the current step.
                tck_n = 1'b0;
                case (state)
                    RST_SEQ: begin
                        if (step_cnt == STEP_W'(5)) begin
                            finish = 1'b1;
                        end else begin
                            step_cnt_n = step_cnt + STEP_W'(1);
                            tms_n      = (step_cnt != STEP_W'(4));   // 1,1,1,1,1,0
                        end
                    end
                    HEADER: begin
                        if (step_cnt == hdr_last) begin
                            state_n   = SHIFT;
                            bit_idx_n = '0;
                            tms_n     = (len_q == LEN_W'(1));
                            tdi_n     = data_q[0];
                            data_n    = data_q >> 1;
                        end else begin
                            step_cnt_n = step_cnt + STEP_W'(1);
                            tms_n      = is_ir_q && (step_cnt == '0);
                        end
                    end
                    SHIFT: begin
                        if (bit_idx == len_q - LEN_W'(1)) begin
                            state_n    = TRAILER;
                            step_cnt_n = '0;
                            tms_n      = 1'b1;
                            tdi_n      = 1'b0;
                        end else begin
                            bit_idx_n = bit_idx + LEN_W'(1);
                            // TMS=1 only on the last shift step (exits to Exit1).
                            tms_n     = ((bit_idx + LEN_W'(2)) == len_q);
                            tdi_n     = data_q[0];
                            data_n    = data_q >> 1;
                        end
                    end
                    TRAILER: begin
                        if (step_cnt == STEP_W'(1)) begin
                            finish = 1'b1;
                        end else begin
                            step_cnt_n = STEP_W'(1);
                            tms_n      = 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end

        // The automatic power-up sequence has no command behind it, so no response.
        if (finish) begin
            state_n    = IDLE;
            tms_n      = 1'b0;
            tdi_n      = 1'b0;
            rsp_pend_n = 1'b0;
            if (rsp_pend) begin
                rsp_valid_n = 1'b1;
                rsp_data_n  = sreg;
            end
        end
    end

    // State and datapath registers; reset forces the safe JTAG drive at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= RST_SEQ;
            div_cnt   <= '0;
            step_cnt  <= '0;
            bit_idx   <= '0;
            len_q     <= '0;
            is_ir_q   <= 1'b0;
            // NOTE: the command and capture registers are reset too; they are
            // flops, not a RAM, and an aborted scan must leave nothing behind.
            data_q    <= '0;
            sreg      <= '0;
            rsp_data  <= '0;
            rsp_pend  <= 1'b0;
            tck       <= 1'b0;
            tms       <= 1'b1;
            tdi       <= 1'b0;
            rsp_valid <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop updates from the
            // same pre-edge values, independent of statement order.
            state     <= state_n;
            div_cnt   <= div_cnt_n;
            step_cnt  <= step_cnt_n;
            bit_idx   <= bit_idx_n;
            len_q     <= len_n;
            is_ir_q   <= is_ir_n;
            data_q    <= data_n;
            sreg      <= sreg_n;
            rsp_data  <= rsp_data_n;
            rsp_pend  <= rsp_pend_n;
            tck       <= tck_n;
            tms       <= tms_n;
            tdi       <= tdi_n;
            rsp_valid <= rsp_valid_n;
        end
    end

endmodule

// File: tb/tb_uart8_jtag_tap_master.sv
// Bench for uart8_jtag_tap_master: a behavioural target TAP (2-bit IR with
// capture 2'b01, one 38-bit DR that captures its own value) plus a
// bit-stream reference model for responses and register contents.
module tb_uart8_jtag_tap_master;

    localparam int CLK_DIV = 2;
    localparam int MAX_LEN = 38;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               cmd_valid = 1'b0;
    logic               cmd_ready;
    logic               cmd_is_ir = 1'b0;
    logic [5:0]         cmd_len = '0;
    logic [MAX_LEN-1:0] cmd_data = '0;
    logic               rsp_valid;
    logic [MAX_LEN-1:0] rsp_data;
    logic               busy;
    logic               tck, tms, tdi;
    logic               tdo = 1'b0;

    int n_cmp = 0;
    int n_err = 0;
    int n_rsp = 0;

    uart8_jtag_tap_master #(.CLK_DIV(CLK_DIV), .MAX_LEN(MAX_LEN)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_is_ir(cmd_is_ir),
        .cmd_len(cmd_len), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
        .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo)
    );

    always #5 clk = ~clk;

    // ---------------- target TAP ----------------
    typedef enum int {TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR,
                      SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR} tap_e;

    tap_e        tap_st = TLR;
    logic [37:0] tap_dr = 38'h15_A5A5_A5A5;
    logic [1:0]  tap_ir = 2'b00;
    logic        tms_q[$];
    logic        tdi_q[$];

    function automatic tap_e tap_next(input tap_e s, input logic m);
        case (s)
            TLR:    return m ? TLR    : RTI;
            RTI:    return m ? SEL_DR : RTI;
            SEL_DR: return m ? SEL_IR : CAP_DR;
            CAP_DR: return m ? EX1_DR : SH_DR;
            SH_DR:  return m ? EX1_DR : SH_DR;
            EX1_DR: return m ? UPD_DR : PA_DR;
            PA_DR:  return m ? EX2_DR : PA_DR;
            EX2_DR: return m ? UPD_DR : SH_DR;
            UPD_DR: return m ? SEL_DR : RTI;
            SEL_IR: return m ? TLR    : CAP_IR;
            CAP_IR: return m ? EX1_IR : SH_IR;
            SH_IR:  return m ? EX1_IR : SH_IR;
            EX1_IR: return m ? UPD_IR : PA_IR;
            PA_IR:  return m ? EX2_IR : PA_IR;
            EX2_IR: return m ? UPD_IR : SH_IR;
            default: return m ? SEL_DR : RTI;
        endcase
    endfunction

    // Target samples TMS/TDI on rising TCK and logs every step it sees.
    always @(posedge tck) begin
        tms_q.push_back(tms);
        tdi_q.push_back(tdi);
        case (tap_st)
            CAP_IR: tap_ir <= 2'b01;
            SH_IR:  tap_ir <= {tdi, tap_ir[1]};
            SH_DR:  tap_dr <= {tdi, tap_dr[37:1]};
            default: ;
        endcase
        tap_st <= tap_next(tap_st, tms);
    end

    // Target updates TDO on falling TCK.
    always @(negedge tck)
        tdo <= (tap_st == SH_DR) ? tap_dr[0] : (tap_st == SH_IR) ? tap_ir[0] : 1'b0;

    // Count every clk cycle in which a response is presented.
    always @(posedge clk)
        if (rsp_valid) n_rsp <= n_rsp + 1;

    // ---------------- reference model ----------------
    logic [37:0] m_dr = 38'h15_A5A5_A5A5;
    logic [1:0]  m_ir = 2'b00;

    // A scan of n bits through an L-bit register holding cur: the bits leaving
    // are cur followed by din; the register keeps the last L bits of that stream.
    function automatic void model_scan(input logic [37:0] cur, input int l, input int n,
                                       input logic [37:0] din,
                                       output logic [37:0] rsp, output logic [37:0] nreg);
        logic stream[$];
        for (int k = 0; k < l; k++) stream.push_back(cur[k]);
        for (int k = 0; k < n; k++) stream.push_back(din[k]);
        rsp  = '0;
        nreg = '0;
        for (int i = 0; i < n; i++) rsp[i] = stream[i];
        for (int j = 0; j < l; j++) nreg[j] = stream[n + j];
    endfunction

    function automatic logic [63:0] pack(input logic q[$]);
        logic [63:0] v = '0;
        foreach (q[i]) if (i < 64) v[i] = q[i];
        return v;
    endfunction

    // Expected per-step TMS and TDI, bit k = step k.
    function automatic void exp_seq(input bit is_ir, input int n, input logic [37:0] din,
                                    output logic [63:0] etms, output logic [63:0] etdi,
                                    output int steps);
        logic qm[$];
        logic qd[$];
        if (n == 0) begin
            for (int k = 0; k < 5; k++) begin qm.push_back(1'b1); qd.push_back(1'b0); end
            qm.push_back(1'b0); qd.push_back(1'b0);
        end else begin
            qm.push_back(1'b1); qd.push_back(1'b0);
            if (is_ir) begin qm.push_back(1'b1); qd.push_back(1'b0); end
            qm.push_back(1'b0); qd.push_back(1'b0);
            qm.push_back(1'b0); qd.push_back(1'b0);
            for (int i = 0; i < n; i++) begin
                qm.push_back(i == n - 1);
                qd.push_back(din[i]);
            end
            qm.push_back(1'b1); qd.push_back(1'b0);
            qm.push_back(1'b0); qd.push_back(1'b0);
        end
        etms  = pack(qm);
        etdi  = pack(qd);
        steps = qm.size();
    endfunction

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic wait_ready(input string nm);
        int k = 0;
        while (cmd_ready !== 1'b1 && k < 500) begin
            @(posedge clk); #1; k++;
        end
        check({nm, ".ready"}, 64'(cmd_ready), 64'd1);
    endtask

    // Issue one command and check latency, response, pulse width, step
    // sequences and the target's final state against the model.
    task automatic run_cmd(input string nm, input bit is_ir, input logic [5:0] len,
                           input logic [37:0] data, input bit has_exp,
                           input logic [37:0] exp_tab);
        int          n;
        int          steps;
        int          cyc;
        int          r0;
        logic [37:0] e_rsp, e_reg;
        logic [63:0] e_tms, e_tdi;

        n = (int'(len) > MAX_LEN) ? MAX_LEN : int'(len);
        e_rsp = '0;
        e_reg = '0;
        if (n > 0) begin
            if (is_ir) model_scan(38'b01, 2, n, data, e_rsp, e_reg);
            else       model_scan(m_dr, 38, n, data, e_rsp, e_reg);
        end
        exp_seq(is_ir, n, data, e_tms, e_tdi, steps);

        wait_ready(nm);
        tms_q.delete();
        tdi_q.delete();
        r0 = n_rsp;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_is_ir = is_ir;
        cmd_len   = len;
        cmd_data  = data;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check({nm, ".busy"}, 64'(busy), 64'd1);

        cyc = 0;
        do begin
            @(posedge clk); #1; cyc++;
        end while (rsp_valid !== 1'b1 && cyc < 1000);
        check({nm, ".latency"}, 64'(cyc), 64'(steps * 2 * CLK_DIV));
        check({nm, ".rsp"}, 64'(rsp_data), 64'(e_rsp));
        if (has_exp) check({nm, ".rsp_tab"}, 64'(rsp_data), 64'(exp_tab));
        check({nm, ".ready_at_rsp"}, 64'(cmd_ready), 64'd1);
        @(posedge clk); #1;
        check({nm, ".pulse"}, 64'(n_rsp - r0), 64'd1);
        check({nm, ".hold"}, 64'(rsp_data), 64'(e_rsp));
        check({nm, ".tms_n"}, 64'(tms_q.size()), 64'(steps));
        check({nm, ".tms"}, pack(tms_q), e_tms);
        check({nm, ".tdi"}, pack(tdi_q), e_tdi);
        check({nm, ".tap_rti"}, 64'(tap_st == RTI), 64'd1);

        if (n > 0) begin
            if (is_ir) m_ir = e_reg[1:0];
            else       m_dr = e_reg;
        end
        check({nm, ".ir"}, 64'(tap_ir), 64'(m_ir));
        check({nm, ".dr"}, 64'(tap_dr), 64'(m_dr));
    endtask

    // Release reset and check the automatic TAP reset sequence.
    task automatic release_and_check(input string nm, input int r0);
        int cyc = 0;
        tms_q.delete();
        tdi_q.delete();
        @(negedge clk);
        reset = 1'b0;
        do begin
            @(posedge clk); #1; cyc++;
        end while (cmd_ready !== 1'b1 && cyc < 200);
        check({nm, ".cycles"}, 64'(cyc), 64'(6 * 2 * CLK_DIV));
        check({nm, ".tms_n"}, 64'(tms_q.size()), 64'd6);
        check({nm, ".tms"}, pack(tms_q), 64'h1F);
        check({nm, ".no_rsp"}, 64'(n_rsp - r0), 64'd0);
        check({nm, ".tap_rti"}, 64'(tap_st == RTI), 64'd1);
    endtask

    typedef struct {
        bit          is_ir;
        logic [5:0]  len;
        logic [37:0] data;
        logic [37:0] exp_rsp;
    } vec_t;

    vec_t tab[5];

    initial begin
        logic [63:0] r;
        logic [37:0] d1, d2, e1, e2, nr1, nr2;
        int          cyc;
        int          g;
        int          r0;

        tab[0] = '{1'b1, 6'd2,  38'h2,            38'h1};
        tab[1] = '{1'b0, 6'd38, 38'h2A_5A5A_5A5A, 38'h15_A5A5_A5A5};
        tab[2] = '{1'b0, 6'd0,  38'h3F_FFFF_FFFF, 38'h0};
        tab[3] = '{1'b0, 6'd50, 38'h01_2345_6789, 38'h2A_5A5A_5A5A};
        tab[4] = '{1'b1, 6'd5,  38'h16,           38'h19};

        // Reset values.
        #2 reset = 1'b1;
        @(posedge clk); #1;
        check("rst.tck", 64'(tck), 64'd0);
        check("rst.tms", 64'(tms), 64'd1);
        check("rst.tdi", 64'(tdi), 64'd0);
        check("rst.ready", 64'(cmd_ready), 64'd0);
        check("rst.busy", 64'(busy), 64'd1);
        check("rst.rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst.rsp_data", 64'(rsp_data), 64'd0);
        @(posedge clk); #1;
        release_and_check("por", n_rsp);

        // Directed table.
        for (int i = 0; i < 5; i++)
            run_cmd($sformatf("tab%0d", i), tab[i].is_ir, tab[i].len, tab[i].data,
                    1'b1, tab[i].exp_rsp);

        // Randomised commands against the model.
        for (int i = 0; i < 14; i++) begin
            r = {$urandom, $urandom};
            run_cmd($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)),
                    6'($urandom_range(0, 63)), r[37:0], 1'b0, '0);
        end

        // Back-to-back DR scans with cmd_valid held high.
        r  = {$urandom, $urandom};
        d1 = r[37:0];
        r  = {$urandom, $urandom};
        d2 = r[37:0];
        model_scan(m_dr, 38, 8, d1, e1, nr1);
        model_scan(nr1, 38, 12, d2, e2, nr2);
        wait_ready("b2b");
        r0 = n_rsp;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_is_ir = 1'b0;
        cmd_len   = 6'd8;
        cmd_data  = d1;
        @(posedge clk); #1;
        cmd_len  = 6'd12;
        cmd_data = d2;
        cyc = 0;
        do begin
            @(posedge clk); #1; cyc++;
        end while (rsp_valid !== 1'b1 && cyc < 1000);
        check("b2b.rsp1", 64'(rsp_data), 64'(e1));
        check("b2b.tck_low", 64'(tck), 64'd0);
        g = 1;
        @(posedge clk); #1;
        check("b2b.accept", 64'(cmd_ready), 64'd0);
        cmd_valid = 1'b0;
        while (tck !== 1'b1 && g < 50) begin
            g++;
            @(posedge clk); #1;
        end
        check("b2b.gap", 64'(g), 64'(CLK_DIV + 1));
        cyc = 0;
        do begin
            @(posedge clk); #1; cyc++;
        end while (rsp_valid !== 1'b1 && cyc < 1000);
        check("b2b.rsp2", 64'(rsp_data), 64'(e2));
        @(posedge clk); #1;
        check("b2b.pulses", 64'(n_rsp - r0), 64'd2);
        m_dr = nr2;
        check("b2b.dr", 64'(tap_dr), 64'(m_dr));

        // Reset asserted in the middle of a DR shift.
        wait_ready("abort");
        r0 = n_rsp;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_is_ir = 1'b0;
        cmd_len   = 6'd38;
        cmd_data  = 38'h3F_FFFF_FFFF;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (22) @(posedge clk);
        #1;
        check("abort.mid_tck", 64'(tck), 64'd1);
        reset = 1'b1;
        #1;
        check("abort.tck", 64'(tck), 64'd0);
        check("abort.tms", 64'(tms), 64'd1);
        check("abort.tdi", 64'(tdi), 64'd0);
        check("abort.ready", 64'(cmd_ready), 64'd0);
        check("abort.busy", 64'(busy), 64'd1);
        check("abort.rsp_data", 64'(rsp_data), 64'd0);
        repeat (3) @(posedge clk);
        release_and_check("abort.rst", r0);
        // The aborted scan left partial shift contents in the target; adopt them.
        m_dr = tap_dr;
        m_ir = tap_ir;

        r = {$urandom, $urandom};
        run_cmd("after_abort", 1'b0, 6'd38, r[37:0], 1'b0, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
